// File: rtl/mat_pkg.sv
// mat_pkg: constants and collector state encoding shared across the matrix add datapath
// (adder, row collector, writeback).
package mat_pkg;
    localparam int MAT_N  = 5;
    localparam int ELEM_W = 8;
    localparam int ROW_W  = MAT_N * ELEM_W;
    localparam int MAT_W  = MAT_N * ROW_W;
    typedef enum logic {COLLECT, DONE} mrc_state_e;
endpackage

// File: rtl/mat_row_collector_if.sv
// mat_row_collector_if: row-in and matrix-out valid/ready handshakes.
// out_ovf_rows exists only when MRC_OVF_ROWMASK_EN is defined.
interface mat_row_collector_if #(
    parameter int N      = mat_pkg::MAT_N,
    parameter int ELEM_W = mat_pkg::ELEM_W
);
    logic                  in_valid;
    logic                  in_ready;
    logic [N*ELEM_W-1:0]   in_row;
    logic                  in_ovf;
    logic                  out_valid;
    logic                  out_ready;
    logic [N*N*ELEM_W-1:0] out_matrix;
    logic                  out_ovf;
`ifdef MRC_OVF_ROWMASK_EN
    logic [N-1:0]          out_ovf_rows;
    modport master (output in_valid, in_row, in_ovf, out_ready,
                    input  in_ready, out_valid, out_matrix, out_ovf, out_ovf_rows);
    modport slave  (input  in_valid, in_row, in_ovf, out_ready,
                    output in_ready, out_valid, out_matrix, out_ovf, out_ovf_rows);
`else
    modport master (output in_valid, in_row, in_ovf, out_ready,
                    input  in_ready, out_valid, out_matrix, out_ovf);
    modport slave  (input  in_valid, in_row, in_ovf, out_ready,
                    output in_ready, out_valid, out_matrix, out_ovf);
`endif
endinterface

// File: rtl/mat_row_collector.sv
// mat_row_collector: assembles N result rows into one matrix with sticky overflow.
// Optional per-row overflow mask via MRC_OVF_ROWMASK_EN.
module mat_row_collector #(
    parameter int N      = mat_pkg::MAT_N,
    parameter int ELEM_W = mat_pkg::ELEM_W
) (
    input logic             clk,
    input logic             rst_n,
    input logic             clr,
    mat_row_collector_if.slave bus
);
    import mat_pkg::*;
    localparam int RW = N * ELEM_W;

    mrc_state_e    state, state_d;
    logic [2:0]    row_idx, idx_d;
    logic [RW-1:0] rows [N];
    logic          write, fire, last, clear_acc;

    // clr wins over both a row accept and an output handshake
    always_comb begin
        write     = state == COLLECT && bus.in_valid && !clr;
        fire      = state == DONE && bus.out_ready;
        last      = row_idx == 3'(N - 1);
        clear_acc = clr || fire;
        state_d   = clr ? COLLECT : (write && last) ? DONE : fire ? COLLECT : state;
        idx_d     = (clr || (write && last)) ? 3'd0 : write ? row_idx + 3'd1 : row_idx;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= COLLECT;
            row_idx <= '0;
        end else begin
            state   <= state_d;
            row_idx <= idx_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) rows[i] <= '0;
        end else if (write) begin
            rows[row_idx] <= bus.in_row;
        end
    end

`ifdef MRC_OVF_ROWMASK_EN
    logic [N-1:0] ovf_rows;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ovf_rows <= '0;
        else if (clear_acc) ovf_rows <= '0;
        else if (write) ovf_rows[row_idx] <= bus.in_ovf;
    end
    assign bus.out_ovf      = |ovf_rows;
    assign bus.out_ovf_rows = ovf_rows;
`else
    logic ovf_acc;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ovf_acc <= 1'b0;
        else if (clear_acc) ovf_acc <= 1'b0;
        else if (write) ovf_acc <= ovf_acc | bus.in_ovf;
    end
    assign bus.out_ovf = ovf_acc;
`endif

    // row 0 lands in the most significant slice of the matrix
    for (genvar r = 0; r < N; r++) begin : g_out
        assign bus.out_matrix[(N-r)*RW-1 -: RW] = rows[r];
    end

    assign bus.in_ready  = state == COLLECT;
    assign bus.out_valid = state == DONE;
endmodule

// File: tb/tb_mat_row_collector.sv
// tb_mat_row_collector: table vectors, directed corner sequences and random traffic
// checked against a queue-based matrix model.
module tb_mat_row_collector;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic clr = 1'b0;
    int   total = 0;
    int   passed = 0;

    always #5 clk = ~clk;

    mat_row_collector_if #(.N(5), .ELEM_W(8)) bus();
    mat_row_collector #(.N(5), .ELEM_W(8)) dut (.clk(clk), .rst_n(rst_n), .clr(clr), .bus(bus.slave));

    typedef struct {
        logic         v;
        logic [39:0]  row;
        logic         ovf;
        logic         ordy;
        logic         e_ir;
        logic         e_ov;
        logic         e_ovf;
        logic [4:0]   e_rows;
        logic [199:0] e_mat;
    } vec_t;
    vec_t vt [13];

    logic [39:0]  mq [$];
    logic         mo [$];
    logic         m_pend;
    logic [199:0] m_mat;
    logic         m_ovf;
    logic [4:0]   m_rows;

    function automatic vec_t mkv(input logic v, input logic [39:0] row, input logic ovf,
                                 input logic ordy, input logic e_ir, input logic e_ov,
                                 input logic e_ovf, input logic [4:0] e_rows, input logic [199:0] e_mat);
        vec_t x;
        x.v = v; x.row = row; x.ovf = ovf; x.ordy = ordy;
        x.e_ir = e_ir; x.e_ov = e_ov; x.e_ovf = e_ovf; x.e_rows = e_rows; x.e_mat = e_mat;
        return x;
    endfunction

    task automatic chk(input string nm, input logic [199:0] act, input logic [199:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    function automatic void m_reset();
        mq.delete();
        mo.delete();
        m_pend = 1'b0;
    endfunction

    // A matrix is the first five rows taken while nothing is pending; clr discards everything.
    function automatic void m_step(input logic v, input logic [39:0] row, input logic ovf,
                                   input logic ordy, input logic c);
        if (c) begin
            m_reset();
        end else if (m_pend) begin
            if (ordy) m_pend = 1'b0;
        end else if (v) begin
            mq.push_back(row);
            mo.push_back(ovf);
            if (mq.size() == 5) begin
                m_mat = '0; m_ovf = 1'b0; m_rows = '0;
                for (int i = 0; i < 5; i++) begin
                    m_mat = {m_mat[159:0], mq[i]};
                    m_ovf = m_ovf | mo[i];
                    m_rows[i] = mo[i];
                end
                mq.delete();
                mo.delete();
                m_pend = 1'b1;
            end
        end
    endfunction

    task automatic cyc(input logic v, input logic [39:0] row, input logic ovf,
                       input logic ordy, input logic c);
        bus.in_valid = v; bus.in_row = row; bus.in_ovf = ovf; bus.out_ready = ordy; clr = c;
        m_step(v, row, ovf, ordy, c);
        @(posedge clk);
        #1;
    endtask

    task automatic cmp_model(input string tag);
        chk({tag, " in_ready"}, bus.in_ready, !m_pend);
        chk({tag, " out_valid"}, bus.out_valid, m_pend);
        if (m_pend) begin
            chk({tag, " out_matrix"}, bus.out_matrix, m_mat);
            chk({tag, " out_ovf"}, bus.out_ovf, m_ovf);
`ifdef MRC_OVF_ROWMASK_EN
            chk({tag, " out_ovf_rows"}, bus.out_ovf_rows, m_rows);
`endif
        end
    endtask

    task automatic reset_checks(input string tag);
        chk({tag, " in_ready"}, bus.in_ready, 1'b1);
        chk({tag, " out_valid"}, bus.out_valid, 1'b0);
        chk({tag, " out_matrix"}, bus.out_matrix, 200'd0);
        chk({tag, " out_ovf"}, bus.out_ovf, 1'b0);
`ifdef MRC_OVF_ROWMASK_EN
        chk({tag, " out_ovf_rows"}, bus.out_ovf_rows, 5'd0);
`endif
    endtask

    initial begin
        logic [39:0]  r1, ra, rb;
        logic [199:0] mat1, mat2;
        int hits [$];
        r1 = 40'h0F23374B5F;
        ra = 40'h05FB05FB05;
        rb = 40'h82BA807FCE;
        mat1 = {r1, r1, r1, r1, r1};
        mat2 = {ra, ra, rb, 40'h0, 40'h0};
        for (int i = 0; i < 4; i++) vt[i] = mkv(1, r1, 0, 0, 1, 0, 0, 5'b0, 200'd0);
        vt[4]  = mkv(1, r1, 0, 0, 0, 1, 0, 5'b0, mat1);
        vt[5]  = mkv(1, r1, 0, 0, 0, 1, 0, 5'b0, mat1);
        vt[6]  = mkv(1, r1, 0, 1, 1, 0, 0, 5'b0, 200'd0);
        vt[7]  = mkv(1, ra, 0, 0, 1, 0, 0, 5'b0, 200'd0);
        vt[8]  = mkv(1, ra, 0, 0, 1, 0, 0, 5'b0, 200'd0);
        vt[9]  = mkv(1, rb, 1, 0, 1, 0, 0, 5'b0, 200'd0);
        vt[10] = mkv(1, 40'h0, 0, 0, 1, 0, 0, 5'b0, 200'd0);
        vt[11] = mkv(1, 40'h0, 0, 0, 0, 1, 1, 5'b00100, mat2);
        vt[12] = mkv(0, 40'h0, 0, 1, 1, 0, 0, 5'b0, 200'd0);

        bus.in_valid = 0; bus.in_row = '0; bus.in_ovf = 0; bus.out_ready = 0;
        m_reset();
        #12;
        reset_checks("reset");
        rst_n = 1'b1;

        for (int i = 0; i < 13; i++) begin
            cyc(vt[i].v, vt[i].row, vt[i].ovf, vt[i].ordy, 1'b0);
            chk($sformatf("vec%0d in_ready", i), bus.in_ready, vt[i].e_ir);
            chk($sformatf("vec%0d out_valid", i), bus.out_valid, vt[i].e_ov);
            if (vt[i].e_ov) begin
                chk($sformatf("vec%0d out_ovf", i), bus.out_ovf, vt[i].e_ovf);
                chk($sformatf("vec%0d out_matrix", i), bus.out_matrix, vt[i].e_mat);
                chk($sformatf("vec%0d row2", i), bus.out_matrix[119:80], rb & {40{vt[i].e_ovf}} | r1 & {40{!vt[i].e_ovf}});
`ifdef MRC_OVF_ROWMASK_EN
                chk($sformatf("vec%0d out_ovf_rows", i), bus.out_ovf_rows, vt[i].e_rows);
`endif
            end
        end

        // output backpressure with an eager upstream
        for (int k = 0; k < 5; k++) cyc(1, 40'(k + 1) * 40'h0101010101, 0, 0, 0);
        cmp_model("bp full");
        for (int k = 0; k < 4; k++) begin
            cyc(1, 40'hDEADBEEF00, 1, 0, 0);
            chk($sformatf("bp%0d in_ready", k), bus.in_ready, 1'b0);
            cmp_model($sformatf("bp%0d", k));
        end
        cyc(1, 40'hDEADBEEF00, 1, 1, 0);
        cmp_model("bp handshake");
        for (int k = 0; k < 5; k++) cyc(1, 40'(k + 7) * 40'h1000000001, 0, 0, 0);
        cmp_model("bp next");
        chk("bp next out_ovf", bus.out_ovf, 1'b0);
        chk("bp next row0", bus.out_matrix[199:160], 40'h7000000007);
        cyc(0, 0, 0, 1, 0);

        // abort with clr colliding with a valid row
        for (int k = 0; k < 3; k++) begin
            cyc(1, 40'hEE000000E0 + 40'(k), 1, 0, 0);
            cmp_model($sformatf("abort pre%0d", k));
        end
        cyc(1, 40'hBADBADBAD0, 1, 0, 1);
        cmp_model("abort clr");
        for (int k = 0; k < 5; k++) cyc(1, 40'h0000000010 + 40'(k), 0, 0, 0);
        cmp_model("abort post");
        chk("abort out_ovf", bus.out_ovf, 1'b0);
        chk("abort out_matrix", bus.out_matrix,
            {40'h0000000010, 40'h0000000011, 40'h0000000012, 40'h0000000013, 40'h0000000014});
        cyc(0, 0, 0, 1, 0);

        // asynchronous reset between edges
        cyc(1, 40'h1122334455, 1, 0, 0);
        cyc(1, 40'h6677889900, 0, 0, 0);
        #2 rst_n = 1'b0;
        #1 reset_checks("async rst");
        #1 rst_n = 1'b1;
        m_reset();
        for (int k = 0; k < 5; k++) begin
            cyc(1, 40'hA0A0A0A0A0 ^ 40'(k * 3), k == 1, 0, 0);
            cmp_model($sformatf("post rst%0d", k));
        end
        cyc(0, 0, 0, 1, 0);
        cmp_model("post rst hs");

        // back-to-back streaming
        for (int i = 0; i < 18; i++) begin
            cyc(1, 40'(i) * 40'h0102030405 + 40'h1, 0, 1, 0);
            cmp_model($sformatf("stream%0d", i));
            if (bus.out_valid) hits.push_back(i);
        end
        chk("stream outputs", 200'(hits.size()), 200'd3);
        for (int j = 1; j < hits.size(); j++)
            chk($sformatf("stream period%0d", j), 200'(hits[j] - hits[j-1]), 200'd6);

        for (int i = 0; i < 400; i++) begin
            cyc($urandom_range(3) != 0, {$urandom, 8'($urandom)}, $urandom_range(7) == 0,
                $urandom_range(2) != 0, $urandom_range(39) == 0);
            cmp_model($sformatf("rnd%0d", i));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
